mips_cpu_state_ctrl: RTL and testbench
======================================

# mips_cpu_state_ctrl

Multi-cycle sequencer for the MIPS CPU core. It generates the one-hot FETCH/EXEC1/EXEC2 phase strobes that drive instruction decode, the register file and the ALU. It stretches phases while the Avalon memory bus or the multiply/divide unit stalls, and it halts the core when the next fetch address is 0. It sits between the bus interface, the instruction decoder and the PC unit.

## Interface
- RESET_IDLE_CYCLES, 1: cycles spent in IDLE after reset release before the first fetch; legal range 1–15.
- COUNTER_WIDTH, 32: width of the performance counters; only used when `STATE_CTRL_PERF_CNT_EN` is defined.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- waitrequest  in  1  Avalon bus stall; high holds the current bus transaction.
- mem_access  in  1  from decode; the current instruction performs a data read or write in EXEC2.
- muldiv_busy  in  1  multiply/divide unit still computing; valid in EXEC2.
- next_pc_zero  in  1  from PC unit; the address of the next fetch is 0x00000000.
- fetch  out  1  high in FETCH.
- exec1  out  1  high in EXEC1.
- exec2  out  1  high in EXEC2.
- active  out  1  core running; low in IDLE and HALTED.
- pc_update_en  out  1  one-cycle pulse on the final EXEC2 cycle of each instruction.
- stall  out  1  current cycle is held by waitrequest or muldiv_busy.
- state  out  3  encoded state: IDLE=0, FETCH=1, EXEC1=2, EXEC2=3, HALTED=4.
- cycle_count, stall_count, retired_count  out  COUNTER_WIDTH each  performance counters; present only with `STATE_CTRL_PERF_CNT_EN`.

## Operation
- States are IDLE, FETCH, EXEC1, EXEC2 and HALTED. The state register is the only state apart from the idle counter and the performance counters.
- IDLE:
  - A 4-bit counter loads 0 on reset and increments each cycle.
  - The controller moves to FETCH after RESET_IDLE_CYCLES cycles in IDLE.
- FETCH:
  - If waitrequest=1, stay in FETCH with stall=1.
  - Otherwise go to EXEC1.
- EXEC1: always goes to EXEC2 after exactly one cycle. It never stalls.
- EXEC2:
  - Hold in EXEC2 when (mem_access & waitrequest) | muldiv_busy.
  - Otherwise pulse pc_update_en. Then go to HALTED if next_pc_zero=1, else to FETCH.
- HALTED: absorbing state. Only reset leaves it.
- Outputs are decoded directly from the state register; there is no combinational path from inputs to fetch, exec1, exec2 or active.
  - active=1 in FETCH, EXEC1 and EXEC2.
  - stall and pc_update_en are combinational from the inputs and the current state.
- waitrequest is ignored in EXEC1, in IDLE, in HALTED, and in EXEC2 when mem_access=0.
- next_pc_zero is sampled only on the final EXEC2 cycle. Its value at any other time is ignored.

## Timing
- Reset values: state=IDLE; fetch, exec1, exec2, active, pc_update_en and stall all 0; all counters 0.
- An unstalled instruction takes 3 cycles, FETCH→EXEC1→EXEC2, with 1 retirement per 3 cycles.
- Each stalled cycle adds exactly 1 cycle to the phase it occurs in.
- The first FETCH occurs RESET_IDLE_CYCLES cycles after the first rising edge with reset=0.
- Simultaneous memory and mul/div stalls in EXEC2 count as a single stall cycle per clock.
- Reset asserted mid-instruction forces IDLE immediately, asynchronously. The in-flight instruction is not retired and pc_update_en does not pulse.
- active falls on the clock edge that enters HALTED and stays 0.

## Configuration
- Macro: `STATE_CTRL_PERF_CNT_EN`.
- Defined: the three counters exist.
  - cycle_count increments every cycle with active=1.
  - stall_count increments every cycle with stall=1.
  - retired_count increments on every pc_update_en pulse.
  - All three wrap modulo 2^COUNTER_WIDTH, are cleared by reset, and freeze in HALTED.
- Undefined: the counter ports and their logic are absent. Sequencing behaviour is identical in both builds.

## Test plan
- Reset release, RESET_IDLE_CYCLES=3, no stalls:
  - fetch is first seen high on the 3rd edge after release.
  - Strobes follow FETCH/EXEC1/EXEC2 repeating with period 3.
  - pc_update_en pulses once every 3 cycles.
- waitrequest held high for 4 cycles in FETCH:
  - FETCH lasts 5 cycles with stall=1 for 4 of them.
  - Then EXEC1. Perf build: stall_count=4.
- mem_access=1 with waitrequest=1 for 2 cycles in EXEC2, and muldiv_busy=1 overlapping for 3 cycles:
  - EXEC2 lasts 4 cycles.
  - pc_update_en pulses only on the 4th.
- next_pc_zero=1 on a stalled EXEC2 cycle, then 1 on the final cycle:
  - Enter HALTED.
  - active=0, no further strobes over 20 cycles.
  - Perf build: cycle_count constant.
- Reset pulsed asynchronously, mid-clock during EXEC2:
  - Outputs go to 0 and state=0 before the next edge.
  - No pc_update_en pulse; counters cleared.
- Perf build, COUNTER_WIDTH=4, 16 unstalled instructions:
  - retired_count wraps to 0.
  - cycle_count=0 after 48 active cycles.

Source files
------------

// File: rtl/mips_cpu_state_ctrl.sv
// mips_cpu_state_ctrl
// Multi-cycle sequencer for the MIPS core. It walks IDLE -> FETCH -> EXEC1 -> EXEC2
// and drives one-hot phase strobes. FETCH is stretched by bus waitrequest. EXEC2 is
// stretched by a data-access waitrequest or a busy multiply/divide unit. The core
// parks in HALTED when the next fetch address is zero.
// Optional feature: define STATE_CTRL_PERF_CNT_EN to add the cycle, stall and
// retired-instruction performance counters.
module mips_cpu_state_ctrl #(
  parameter int unsigned RESET_IDLE_CYCLES = 1,
  parameter int unsigned COUNTER_WIDTH     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic       mem_access,
  input  logic       muldiv_busy,
  input  logic       next_pc_zero,
  output logic       fetch,
  output logic       exec1,
  output logic       exec2,
  output logic       active,
  output logic       pc_update_en,
  output logic       stall,
  output logic [2:0] state
`ifdef STATE_CTRL_PERF_CNT_EN
  ,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] stall_count,
  output logic [COUNTER_WIDTH-1:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC1  = 3'd2,
    ST_EXEC2  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // Idle counter value on the last IDLE cycle before the first fetch.
  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  // Reject parameter values outside the supported range at elaboration.
  if ((RESET_IDLE_CYCLES < 1) || (RESET_IDLE_CYCLES > 15) || (COUNTER_WIDTH < 1)) begin : g_param_check
    $error("mips_cpu_state_ctrl: RESET_IDLE_CYCLES must be 1..15 and COUNTER_WIDTH >= 1");
  end

  // Phase strobes for a state: {fetch, exec1, exec2, active}.
  function automatic logic [3:0] decode_strobes(input state_t s);
    logic [3:0] strobes;
    case (s)
      ST_FETCH: strobes = 4'b1001;
      ST_EXEC1: strobes = 4'b0101;
      ST_EXEC2: strobes = 4'b0011;
      default:  strobes = 4'b0000;
    endcase
    return strobes;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] idle_cnt_r;
  logic [3:0] idle_cnt_nxt_s;
  logic       fetch_r;
  logic       exec1_r;
  logic       exec2_r;
  logic       active_r;
  logic       hold_exec2_s;
  logic       stall_s;
  logic       pc_update_en_s;
  logic [3:0] strobes_nxt_s;

  // EXEC2 holds for a pending data access on a stalled bus or for a busy mul/div.
  assign hold_exec2_s = (mem_access & waitrequest) | muldiv_busy;

  // Next-state logic together with the combinational stall and retire strobes.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = idle_cnt_r;
    stall_s        = 1'b0;
    pc_update_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idle_cnt_nxt_s = idle_cnt_r + 4'd1;
        if (idle_cnt_r == IDLE_LAST) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (waitrequest) begin
          stall_s     = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        state_nxt_s = ST_EXEC2;
      end
      ST_EXEC2: begin
        if (hold_exec2_s) begin
          stall_s     = 1'b1;
          state_nxt_s = ST_EXEC2;
        end else begin
          pc_update_en_s = 1'b1;
          if (next_pc_zero) begin
            state_nxt_s = ST_HALTED;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        // Unused encodings fall back to IDLE so the core restarts cleanly.
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign strobes_nxt_s = decode_strobes(state_nxt_s);

  // State register, idle counter and the strobes registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idle_cnt_r <= 4'd0;
      fetch_r    <= 1'b0;
      exec1_r    <= 1'b0;
      exec2_r    <= 1'b0;
      active_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      fetch_r    <= strobes_nxt_s[3];
      exec1_r    <= strobes_nxt_s[2];
      exec2_r    <= strobes_nxt_s[1];
      active_r   <= strobes_nxt_s[0];
    end
  end

  assign fetch        = fetch_r;
  assign exec1        = exec1_r;
  assign exec2        = exec2_r;
  assign active       = active_r;
  assign stall        = stall_s;
  assign pc_update_en = pc_update_en_s;
  assign state        = state_r;

`ifdef STATE_CTRL_PERF_CNT_EN
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNTER_WIDTH-1:0] cycle_count_r;
  logic [COUNTER_WIDTH-1:0] stall_count_r;
  logic [COUNTER_WIDTH-1:0] retired_count_r;

  // Wrapping performance counters; all inputs to them are 0 in HALTED, so they freeze there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_r   <= CNT_ZERO;
      stall_count_r   <= CNT_ZERO;
      retired_count_r <= CNT_ZERO;
    end else begin
      if (active_r) begin
        cycle_count_r <= cycle_count_r + CNT_ONE;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
      if (stall_s) begin
        stall_count_r <= stall_count_r + CNT_ONE;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (pc_update_en_s) begin
        retired_count_r <= retired_count_r + CNT_ONE;
      end else begin
        retired_count_r <= retired_count_r;
      end
    end
  end

  assign cycle_count   = cycle_count_r;
  assign stall_count   = stall_count_r;
  assign retired_count = retired_count_r;
`endif

endmodule

// File: tb/tb_mips_cpu_state_ctrl.sv
// Self-checking bench for mips_cpu_state_ctrl (RESET_IDLE_CYCLES=3, COUNTER_WIDTH=4).
// Each scenario task walks a per-cycle table: inputs for the cycle plus the state,
// stall and pc_update_en expected in it. Expected vectors are queued when the inputs
// are driven and popped when the outputs are sampled mid-cycle.
module tb_mips_cpu_state_ctrl;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       waitrequest = 1'b0;
  logic       mem_access = 1'b0;
  logic       muldiv_busy = 1'b0;
  logic       next_pc_zero = 1'b0;
  logic       fetch, exec1, exec2, active, pc_update_en, stall;
  logic [2:0] state;
`ifdef STATE_CTRL_PERF_CNT_EN
  logic [CW-1:0] cycle_count, stall_count, retired_count;
`endif

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mips_cpu_state_ctrl #(
    .RESET_IDLE_CYCLES(3),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .waitrequest(waitrequest),
    .mem_access(mem_access),
    .muldiv_busy(muldiv_busy),
    .next_pc_zero(next_pc_zero),
    .fetch(fetch),
    .exec1(exec1),
    .exec2(exec2),
    .active(active),
    .pc_update_en(pc_update_en),
    .stall(stall),
    .state(state)
`ifdef STATE_CTRL_PERF_CNT_EN
    ,
    .cycle_count(cycle_count),
    .stall_count(stall_count),
    .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  // Observed output vector: {state, fetch, exec1, exec2, active, stall, pc_update_en}.
  wire [8:0] obs = {state, fetch, exec1, exec2, active, stall, pc_update_en};

  localparam logic [2:0] I = 3'd0, F = 3'd1, E1 = 3'd2, E2 = 3'd3, H = 3'd4;

  // Expected output vector for a state, with the expected stall and pc_update_en.
  function automatic logic [8:0] expv(input logic [2:0] st, input logic stl, input logic pcu);
    logic act;
    act = (st == F) || (st == E1) || (st == E2);
    return {st, st == F, st == E1, st == E2, act, stl, pcu};
  endfunction

  // Table row: {waitrequest, mem_access, muldiv_busy, next_pc_zero, state, stall, pcu}.
  function automatic logic [8:0] row(input logic wr, input logic ma, input logic mb,
                                     input logic npz, input logic [2:0] st,
                                     input logic stl, input logic pcu);
    return {wr, ma, mb, npz, st, stl, pcu};
  endfunction

  task automatic test_reset();
    logic [8:0] want;
    repeat (2) @(negedge clk);
    exp_q.push_back(expv(I, 1'b0, 1'b0));
    #1;
    want = exp_q.pop_front();
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, want);
    end
`ifdef STATE_CTRL_PERF_CNT_EN
    n_checks++;
    if ({cycle_count, stall_count, retired_count} !== {(3*CW){1'b0}}) begin
      n_errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", cycle_count, stall_count, retired_count);
    end
`endif
    reset = 1'b0;
  endtask

  // Starts just after reset release; ends in the EXEC2 cycle that leads back to FETCH.
  task automatic test_reset_release();
    logic [8:0] rows[$];
    logic [8:0] want;
    rows = '{row(1'b1, 1'b1, 1'b1, 1'b1, I, 1'b0, 1'b0), row(1'b1, 1'b0, 1'b1, 1'b0, I, 1'b0, 1'b0),
             row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0), row(1'b0, 1'b0, 1'b0, 1'b0, E1, 1'b0, 1'b0),
             row(1'b0, 1'b0, 1'b0, 1'b0, E2, 1'b0, 1'b1), row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0),
             row(1'b0, 1'b0, 1'b0, 1'b0, E1, 1'b0, 1'b0), row(1'b0, 1'b0, 1'b0, 1'b0, E2, 1'b0, 1'b1)};
    foreach (rows[i]) begin
      @(negedge clk);
      {waitrequest, mem_access, muldiv_busy, next_pc_zero} = rows[i][8:5];
      exp_q.push_back(expv(rows[i][4:2], rows[i][1], rows[i][0]));
      #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL reset_release[%0d]: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic [8:0] rows[$];
    logic [8:0] want;
    rows = '{row(1'b1, 1'b0, 1'b0, 1'b1, F, 1'b1, 1'b0), row(1'b1, 1'b0, 1'b0, 1'b0, F, 1'b1, 1'b0),
             row(1'b1, 1'b1, 1'b1, 1'b0, F, 1'b1, 1'b0), row(1'b1, 1'b0, 1'b0, 1'b0, F, 1'b1, 1'b0),
             row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0), row(1'b1, 1'b1, 1'b0, 1'b1, E1, 1'b0, 1'b0),
             row(1'b1, 1'b0, 1'b0, 1'b0, E2, 1'b0, 1'b1)};
    foreach (rows[i]) begin
      @(negedge clk);
      {waitrequest, mem_access, muldiv_busy, next_pc_zero} = rows[i][8:5];
      exp_q.push_back(expv(rows[i][4:2], rows[i][1], rows[i][0]));
      #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL fetch_stall[%0d]: got %b want %b", i, obs, want);
      end
    end
`ifdef STATE_CTRL_PERF_CNT_EN
    n_checks++;
    if (stall_count !== CW'(4)) begin
      n_errors++;
      $display("FAIL fetch_stall_count: got %0d want 4", stall_count);
    end
`endif
  endtask

  task automatic test_exec2_stall();
    logic [8:0] rows[$];
    logic [8:0] want;
    rows = '{row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0), row(1'b0, 1'b1, 1'b1, 1'b0, E1, 1'b0, 1'b0),
             row(1'b1, 1'b1, 1'b1, 1'b0, E2, 1'b1, 1'b0), row(1'b1, 1'b1, 1'b1, 1'b1, E2, 1'b1, 1'b0),
             row(1'b0, 1'b1, 1'b1, 1'b0, E2, 1'b1, 1'b0), row(1'b0, 1'b1, 1'b0, 1'b0, E2, 1'b0, 1'b1)};
    foreach (rows[i]) begin
      @(negedge clk);
      {waitrequest, mem_access, muldiv_busy, next_pc_zero} = rows[i][8:5];
      exp_q.push_back(expv(rows[i][4:2], rows[i][1], rows[i][0]));
      #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL exec2_stall[%0d]: got %b want %b", i, obs, want);
      end
    end
`ifdef STATE_CTRL_PERF_CNT_EN
    n_checks++;
    if (stall_count !== CW'(7)) begin
      n_errors++;
      $display("FAIL exec2_stall_count: got %0d want 7", stall_count);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [8:0] rows[$];
    logic [8:0] want;
    rows = '{row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0), row(1'b0, 1'b0, 1'b0, 1'b0, E1, 1'b0, 1'b0),
             row(1'b0, 1'b0, 1'b0, 1'b0, E2, 1'b0, 1'b1)};
    foreach (rows[i]) begin
      @(negedge clk);
      {waitrequest, mem_access, muldiv_busy, next_pc_zero} = rows[i][8:5];
      exp_q.push_back(expv(rows[i][4:2], rows[i][1], rows[i][0]));
      #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL async_reset_pre[%0d]: got %b want %b", i, obs, want);
      end
    end
    #2;
    reset = 1'b1;
    exp_q.push_back(expv(I, 1'b0, 1'b0));
    #1;
    want = exp_q.pop_front();
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL async_reset_immediate: got %b want %b", obs, want);
    end
`ifdef STATE_CTRL_PERF_CNT_EN
    n_checks++;
    if ({cycle_count, stall_count, retired_count} !== {(3*CW){1'b0}}) begin
      n_errors++;
      $display("FAIL async_reset_counters: got %0d/%0d/%0d want 0/0/0", cycle_count, stall_count, retired_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Fresh reset, then 16 unstalled instructions; ends in the following FETCH cycle.
  task automatic test_perf_wrap();
    logic [8:0] rows[$];
    logic [8:0] want;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rows = '{row(1'b0, 1'b0, 1'b0, 1'b0, I, 1'b0, 1'b0), row(1'b0, 1'b0, 1'b0, 1'b0, I, 1'b0, 1'b0)};
    for (int n = 0; n < 16; n++) begin
      rows.push_back(row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0));
      rows.push_back(row(1'b0, 1'b0, 1'b0, 1'b1, E1, 1'b0, 1'b0));
      rows.push_back(row(1'b0, 1'b0, 1'b0, 1'b0, E2, 1'b0, 1'b1));
    end
    rows.push_back(row(1'b0, 1'b0, 1'b0, 1'b0, F, 1'b0, 1'b0));
    foreach (rows[i]) begin
      @(negedge clk);
      {waitrequest, mem_access, muldiv_busy, next_pc_zero} = rows[i][8:5];
      exp_q.push_back(expv(rows[i][4:2], rows[i][1], rows[i][0]));
      #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL perf_wrap[%0d]: got %b want %b", i, obs, want);
      end
    end
`ifdef STATE_CTRL_PERF_CNT_EN
    n_checks++;
    if ({cycle_count, stall_count, retired_count} !== {(3*CW){1'b0}}) begin
      n_errors++;
      $display("FAIL perf_wrap_counters: got %0d/%0d/%0d want 0/0/0", cycle_count, stall_count, retired_count);
    end
`endif
  endtask

  // Continues from the FETCH cycle left by test_perf_wrap.
  task automatic test_halt();
    logic [8:0] rows[$];
    logic [8:0] want;
    rows = '{row(1'b0, 1'b0, 1'b0, 1'b1, E1, 1'b0, 1'b0), row(1'b0, 1'b0, 1'b1, 1'b1, E2, 1'b1, 1'b0),
             row(1'b0, 1'b0, 1'b0, 1'b1, E2, 1'b0, 1'b1)};
    for (int n = 0; n < 20; n++) begin
      rows.push_back(row(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                         1'($urandom_range(1)), H, 1'b0, 1'b0));
    end
    foreach (rows[i]) begin
      @(negedge clk);
      {waitrequest, mem_access, muldiv_busy, next_pc_zero} = rows[i][8:5];
      exp_q.push_back(expv(rows[i][4:2], rows[i][1], rows[i][0]));
      #1;
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL halt[%0d]: got %b want %b", i, obs, want);
      end
    end
`ifdef STATE_CTRL_PERF_CNT_EN
    n_checks++;
    if ({cycle_count, stall_count, retired_count} !== {CW'(4), CW'(1), CW'(1)}) begin
      n_errors++;
      $display("FAIL halt_counters: got %0d/%0d/%0d want 4/1/1", cycle_count, stall_count, retired_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_fetch_stall();
    test_exec2_stall();
    test_async_reset();
    test_reset_release();
    test_perf_wrap();
    test_halt();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
